// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the fetch PC, issues one IMEM request at a time over req/gnt/rvalid,
// buffers responses in a small FIFO and drives a registered idata/pc_out pair.
// idata == 0 is a bubble. Optional macro FETCH_BYPASS_EN lets a response load
// the output register directly when the FIFO is empty (one cycle earlier).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] idata,
    output logic [31:0] pc_out,
    output logic        inst_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      fifo_data_p0 [FIFO_DEPTH];
    logic [31:0]      fifo_pc_p0   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_empty, fifo_full, granted, resp_ok, push, pop, bypass;
    logic             unused_pc_bits;

    // Target low bits are ignored; fetches are always word aligned.
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    // A request reserves a FIFO slot, so none is issued while the FIFO is full.
    assign imem_req   = reset_n && (state_q == S_REQ) && !fifo_full;
    assign imem_addr  = fetch_pc_q;
    assign granted    = imem_req && imem_gnt;
    assign resp_ok    = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    assign bypass     = resp_ok && fifo_empty && !stall;
`else
    assign bypass     = 1'b0;
`endif
    assign push       = resp_ok && !bypass;
    assign pop        = !redirect_valid && !stall && !fifo_empty;

    // Next-state logic: redirect wins; a granted-but-unreturned request forces a drain.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if ((((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid) || granted)
                state_d = S_DRAIN;
            else
                state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (granted) begin
                        state_d    = S_WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                S_WAIT:  if (imem_rvalid) state_d = S_REQ;
                S_DRAIN: if (imem_rvalid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // Control state: FSM, fetch PC, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage (stage p0): response word tagged with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_p0[wr_ptr_q] <= imem_rdata;
            fifo_pc_p0[wr_ptr_q]   <= req_pc_q;
        end
    end

    // Decoder-facing register (stage p1): head of FIFO, bypassed response, or bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idata      <= '0;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else if (redirect_valid) begin
            idata      <= '0;
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if (!fifo_empty) begin
                idata      <= fifo_data_p0[rd_ptr_q];
                pc_out     <= fifo_pc_p0[rd_ptr_q];
                inst_valid <= 1'b1;
            end else if (bypass) begin
                idata      <= imem_rdata;
                pc_out     <= req_pc_q;
                inst_valid <= 1'b1;
            end else begin
                idata      <= '0;
                inst_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and a randomized run
// checked every cycle against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic [31:0] idata;
    logic [31:0] pc_out;
    logic        inst_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .idata(idata), .pc_out(pc_out), .inst_valid(inst_valid)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return ((a * 32'h9E37_79B1) ^ 32'h0000_0013) | 32'h1;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc, m_out_pc, m_idata, m_pcout;
    bit          m_pending, m_discard, m_valid;

    function automatic bit m_req();
        return reset_n && !m_pending && (q.size() < DEPTH);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_pc = RESET_PC; m_out_pc = '0; m_pending = 0; m_discard = 0;
        m_idata = '0; m_pcout = '0; m_valid = 0;
    endfunction

    function automatic void model_step(input bit gnt, input bit rv, input logic [31:0] rdata,
                                       input bit redir, input logic [31:0] rpc, input bit stl);
        bit   granted, resp, taken;
        ent_t e;
        granted = m_req() && gnt;
        resp    = m_pending && rv;
        taken   = 0;
        if (redir) begin
            q.delete();
            m_idata = '0; m_valid = 0;
            m_discard = (m_pending && !rv) || granted;
            m_pending = m_discard;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (!stl) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_idata = e.data; m_pcout = e.pc; m_valid = 1;
                end else if (BYP && resp && !m_discard) begin
                    m_idata = rdata; m_pcout = m_out_pc; m_valid = 1; taken = 1;
                end else begin
                    m_idata = '0; m_valid = 0;
                end
            end
            if (resp) begin
                if (!m_discard && !taken) q.push_back('{m_out_pc, rdata});
                m_pending = 0; m_discard = 0;
            end
            if (granted) begin
                m_pending = 1; m_discard = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic compare_model();
        check32("model_req",   {31'b0, imem_req},   {31'b0, m_req()});
        check32("model_addr",  imem_addr,           m_pc);
        check32("model_idata", idata,               m_idata);
        check32("model_pc",    pc_out,              m_pcout);
        check32("model_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    endtask

    // Drive at negedge, clock, step model, sample 1 unit after the edge, return at negedge.
    task automatic tick(input bit gnt, input bit rv, input logic [31:0] rdata,
                        input bit redir, input logic [31:0] rpc, input bit stl);
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
        redirect_valid = redir; redirect_pc = rpc; stall = stl;
        @(posedge clk);
        model_step(gnt, rv, rdata, redir, rpc, stl);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    // IMEM that grants immediately and answers the cycle after the grant.
    task automatic auto_tick(input bit redir, input logic [31:0] rpc, input bit stl);
        tick(1'b1, m_pending, m_discard ? 32'hDEAD_BEEF : mem(m_out_pc), redir, rpc, stl);
    endtask

    task automatic do_reset();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect_valid = 0; redirect_pc = '0; stall = 0;
        reset_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check32("rst_req",   {31'b0, imem_req},   32'h0);
        check32("rst_addr",  imem_addr,           RESET_PC);
        check32("rst_idata", idata,               32'h0);
        check32("rst_pc",    pc_out,              32'h0);
        check32("rst_valid", {31'b0, inst_valid}, 32'h0);
        reset_n = 1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] epc, input logic [31:0] edata);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            auto_tick(1'b0, 32'h0, 1'b0);
            if (inst_valid) found = 1;
        end
        check32({name, "_found"}, {31'b0, found}, 32'h1);
        if (found) begin
            check32({name, "_pc"},    pc_out, epc);
            check32({name, "_idata"}, idata,  edata);
        end
    endtask

    typedef struct {
        bit gnt; bit rv; logic [31:0] rdata; bit stl;
        bit e_req; logic [31:0] e_addr; logic [31:0] e_idata; logic [31:0] e_pc; bit e_v;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_pc[$];
        logic [31:0] got_d[$];
        logic [31:0] hold_d, hold_pc;

        // Instant-ish IMEM after reset, no stall: addresses 0,4,8 with bubbles between.
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4, 32'h0,         32'h0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b1, 32'h4, 32'h0,         32'h0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8, 32'h0050_0093, 32'h0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b1, 32'h8, 32'h0,         32'h0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'hC, 32'h00A0_0113, 32'h4, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 32'h0020_8193, 1'b0, 1'b1, 32'hC, 32'h0,         32'h4, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC, 32'h0020_8193, 32'h8, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC, 32'h0,         32'h8, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, 1'b0, 32'h0, tbl[i].stl);
`ifndef FETCH_BYPASS_EN
            check32($sformatf("tbl%0d_req", i),   {31'b0, imem_req},   {31'b0, tbl[i].e_req});
            check32($sformatf("tbl%0d_addr", i),  imem_addr,           tbl[i].e_addr);
            check32($sformatf("tbl%0d_idata", i), idata,               tbl[i].e_idata);
            check32($sformatf("tbl%0d_pc", i),    pc_out,              tbl[i].e_pc);
            check32($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_v});
`endif
        end

        // Stall for 6 cycles: FIFO fills, request drops, outputs frozen; then drain in order.
        do_reset();
        wait_valid("stall_pre", 32'h0, mem(32'h0));
        hold_d = idata; hold_pc = pc_out;
        for (int i = 0; i < 6; i++) begin
            auto_tick(1'b0, 32'h0, 1'b1);
            check32("stall_idata_frozen", idata,  hold_d);
            check32("stall_pc_frozen",    pc_out, hold_pc);
        end
        check32("stall_full_req", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            auto_tick(1'b0, 32'h0, 1'b0);
            if (inst_valid) begin got_pc.push_back(pc_out); got_d.push_back(idata); end
        end
        check32("stall_release_count", {31'b0, got_pc.size() >= 3}, 32'h1);
        for (int k = 0; k < 3 && k < got_pc.size(); k++) begin
            check32($sformatf("stall_release_pc%0d", k),    got_pc[k], 32'h4 * (k + 1));
            check32($sformatf("stall_release_idata%0d", k), got_d[k],  mem(32'h4 * (k + 1)));
        end

        // Redirect to 0x103 while a response is outstanding: flush, drain, resume at 0x100.
        do_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, mem(32'h0), 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
        check32("redir_wait_idata", idata,               32'h0);
        check32("redir_wait_valid", {31'b0, inst_valid}, 32'h0);
        check32("redir_wait_req",   {31'b0, imem_req},   32'h0);
        tick(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        check32("redir_drain_req",   {31'b0, imem_req}, 32'h1);
        check32("redir_drain_addr",  imem_addr,         32'h100);
        check32("redir_drain_idata", idata,             32'h0);
        wait_valid("redir_first", 32'h100, mem(32'h100));

        // Redirect coinciding with rvalid under stall: response dropped, FIFO flushed.
        do_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, mem(32'h0), 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, mem(32'h4), 1'b1, 32'h200, 1'b1);
        check32("redir_rv_req",   {31'b0, imem_req},   32'h1);
        check32("redir_rv_addr",  imem_addr,           32'h200);
        check32("redir_rv_idata", idata,               32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check32("redir_rv_empty_idata", idata,               32'h0);
        check32("redir_rv_empty_valid", {31'b0, inst_valid}, 32'h0);
        wait_valid("redir_rv_first", 32'h200, mem(32'h200));

        // Grant withheld: request and address stay put; PC advances only on grant.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check32("nogrant_req",  {31'b0, imem_req}, 32'h1);
            check32("nogrant_addr", imem_addr,         32'h0);
        end
        tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check32("grant_addr", imem_addr,         32'h4);
        check32("grant_req",  {31'b0, imem_req}, 32'h0);

        // Asynchronous reset in the middle of an outstanding fetch.
        do_reset();
        auto_tick(1'b0, 32'h0, 1'b0);
        auto_tick(1'b0, 32'h0, 1'b0);
        auto_tick(1'b0, 32'h0, 1'b0);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check32("async_req",   {31'b0, imem_req},   32'h0);
        check32("async_addr",  imem_addr,           RESET_PC);
        check32("async_idata", idata,               32'h0);
        check32("async_pc",    pc_out,              32'h0);
        check32("async_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1;
        tick(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 32'h0, 1'b0);
        check32("late_rv_idata", idata,             32'h0);
        check32("late_rv_req",   {31'b0, imem_req}, 32'h1);
        check32("late_rv_addr",  imem_addr,         RESET_PC);
        wait_valid("after_reset_first", RESET_PC, mem(RESET_PC));

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          g, rv, rd, st;
            logic [31:0] d, rp;
            rd = ($urandom_range(99) < 4);
            g  = !rd && ($urandom_range(99) < 60);
            st = ($urandom_range(99) < 30);
            if (m_pending) begin
                rv = ($urandom_range(99) < 50);
                d  = m_discard ? $urandom : mem(m_out_pc);
            end else begin
                rv = ($urandom_range(99) < 2);
                d  = $urandom;
            end
            rp = $urandom;
            tick(g, rv, d, rd, rp, st);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and issues requests to IMEM over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and drives a registered idata/pc pair into the decoder.
- Drives idata = 32'b0 as a bubble whenever no valid instruction is available; the decoder treats an all-zero word as "no instruction".
- Accepts a redirect (branch/jump target) and a stall from the downstream pipeline.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; bits [1:0] always 00
imem_gnt  in  1  IMEM accepts request this cycle
imem_rvalid  in  1  imem_rdata valid this cycle
imem_rdata  in  32  returned instruction word
redirect_valid  in  1  redirect fetch to redirect_pc; flush everything
redirect_pc  in  32  redirect target; bits [1:0] ignored
stall  in  1  downstream cannot accept; hold idata/pc_out
idata  out  32  instruction to decoder; 0 = bubble
pc_out  out  32  PC of idata
inst_valid  out  1  1 when idata holds a real instruction

Behaviour:
- Reset (async assert, sync-safe deassert): fetch_pc=RESET_PC, FIFO empty, state S_REQ, imem_req=0, imem_addr=RESET_PC, idata=0, pc_out=0, inst_valid=0.
- FSM states:
  - S_REQ: imem_req=1 iff fifo_count < FIFO_DEPTH (the slot is reserved for the response). imem_addr=fetch_pc, held stable until gnt. On req&gnt: go to S_WAIT, fetch_pc += 4 (32-bit wrap, no flag).
  - S_WAIT: imem_req=0. On rvalid: push {req_pc, imem_rdata}, go to S_REQ.
  - S_DRAIN: imem_req=0. A redirect occurred while a response was outstanding. On rvalid: discard the data, go to S_REQ.
- Only one request is outstanding at any time. rvalid arriving in S_REQ is ignored (protocol error; no state change).
- Output register update, when stall=0:
  - FIFO non-empty: load head into idata/pc_out, set inst_valid=1, pop.
  - FIFO empty: idata=0, inst_valid=0, pc_out holds.
- Output register when stall=1: idata, pc_out and inst_valid hold; no pop.
- Latency (no bypass): gnt at edge E, rvalid earliest in cycle E+1. Data is pushed at that edge and appears on idata one edge later.
- Redirect (redirect_valid=1 at an edge), highest priority over stall, gnt and rvalid:
  - FIFO flushed, idata=0, inst_valid=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - Next state is S_DRAIN if a request was granted and not yet returned (state S_WAIT, rvalid=0). Otherwise S_REQ. This includes the case where rvalid coincides with the redirect; that data is dropped.
  - A request pending without gnt in S_REQ is withdrawn. The address changes to the redirect target the next cycle.
- Redirect while in S_DRAIN: update fetch_pc and stay in S_DRAIN.
- Full FIFO: no new request issued. Push and pop on the same edge is legal, and the count is unchanged.
- Simultaneous push and pop on an empty FIFO (no bypass): push happens, output becomes bubble that cycle.

Optional Feature:
FETCH_BYPASS_EN
- Defined: if the FIFO is empty, stall=0, no redirect and rvalid is accepted in S_WAIT, the response loads straight into idata/pc_out/inst_valid at that edge with no push. This saves one cycle.
- Undefined: all responses pass through the FIFO. Latency is as stated above.

Test Plan:
- Reset release, IMEM gnt same cycle, rvalid next cycle, stall=0 -> imem_addr sequence 0x0,0x4,0x8; first idata (0x00500093 at pc 0x0) appears 2 edges after gnt (1 with FETCH_BYPASS_EN); bubbles (idata=0) between fetches.
- stall=1 held 6 cycles with instant IMEM -> FIFO fills to 2, imem_req drops to 0, idata/pc_out frozen; release -> 3 consecutive valid instructions with PCs in order, no loss or duplication.
- redirect_valid with redirect_pc=0x103 while in S_WAIT -> next idata=0; rvalid data discarded; next imem_addr=0x100; first valid pc_out=0x100.
- redirect asserted same cycle as rvalid and stall=1 -> response dropped, FIFO empty, idata=0 next cycle, fetch resumes at the target.
- gnt withheld 3 cycles -> imem_req=1 and imem_addr constant throughout; fetch_pc advances by 4 only after gnt.
- reset_n asserted mid-S_WAIT -> outputs zero immediately (asynchronous); after release, fetch restarts at RESET_PC and a late rvalid is ignored.
